timer_bamse_multi: RTL and testbench
====================================

Name: timer_bamse_multi

Overview:
- Parametrised successor to the single-channel BAMSE port timer.
- Provides NCH independent up-counting timers of WIDTH bits on the PicoBlaze 8-bit port bus (address/config_in/config_out/ren/wen).
- Each channel has a per-channel prescaler, one-shot or auto-reload mode, an interrupt enable, a sticky write-1-to-clear flag and atomic multi-byte reload/count access.
- All channel interrupts are combined into one irq line for the processor.

Parameters:
- ADDR, 8'h00: base port address; channel c occupies ADDR+4c .. ADDR+4c+3.
- NCH, 2: number of channels, legal range 1..4.
- WIDTH, 16: counter width, legal range 9..16; bits above WIDTH read 0 and are ignored on write.

Ports:
- clk, in, 1: system clock; all logic on the rising edge.
- rst, in, 1: synchronous, active-low reset.
- address, in, 8: port address.
- config_in, in, 8: write data.
- config_out, out, 8: registered read data.
- ren, in, 1: read strobe.
- wen, in, 1: write strobe.
- irq, out, 1: OR over channels of (flag & irq_en).
- rolloff, out, NCH: one-cycle pulse per channel on rolloff.

Behaviour:
- Register map, offset from ADDR+4c:
  - +0 CTRL: [0] en, [1] go (write) / running (read), [2] auto_load, [3] irq_en, [6:4] presc, [7] 0.
  - +1 STATUS: [0] flag (write 1 to clear), [1] running, others 0.
  - +2 LO: write stages reload[7:0]; read returns count[7:0] and snapshots count[WIDTH-1:8] into a shadow.
  - +3 HI: write commits {config_in, staged LO} to reload; read returns the shadow.
- Addresses outside ADDR .. ADDR+4*NCH-1 are ignored: no write effect, and reads return 0.
- Reset (rst==0 at an edge):
  - Cleared to 0: CTRL, reload, staged LO, count, prescaler counter, running, flag, shadow, config_out, rolloff.
  - irq=0.
  - Reset takes priority over any bus access in the same cycle, and applies mid-count.
- Read timing: config_out updates at the edge where ren=1 (one-cycle latency). When ren=0 it is 0 at the next edge.
- Bus strobes: ren and wen are sampled each edge. A strobe held for k cycles acts k times; writes are idempotent except go, which restarts.
- CTRL write with go=1:
  - At that edge, count<=reload, prescaler counter<=0, running<=1.
  - en, auto_load, irq_en and presc take the written values.
- CTRL write with go=0: updates the fields only; running and count are unchanged.
- Tick: for channel c, tick=running & en & (presc counter == 2^presc-1). The prescaler counter advances only while running & en, and wraps to 0 on a tick.
- On a tick with count != 2^WIDTH-1: count<=count+1.
- On a tick with count == 2^WIDTH-1 (rolloff):
  - flag<=1 and rolloff[c] pulses high for one cycle.
  - If auto_load=1: count<=reload and running stays 1.
  - Else: count<=reload and running<=0.
- Period from a go write to the flag being set: (2^WIDTH - reload) * 2^presc cycles.
- en=0 freezes count and the prescaler counter; running is kept. Setting en=1 again resumes from the frozen state.
- Simultaneous events:
  - Rolloff and a STATUS W1C in the same cycle: set wins, flag=1.
  - go write and rolloff in the same cycle: go wins (count<=reload, running=1), but the flag is still set.
  - HI write while running: the new reload applies only at the next go or auto-reload.
  - LO write without a following HI write: reload is unchanged.
- irq is combinational from the registered flag and irq_en, with no extra latency. Writing irq_en=0 masks irq but the flag is kept.

Test Plan:
- Reset/idle: drive rst=0 for 2 cycles, then read every address -> config_out=0, irq=0, rolloff=0. Write at ADDR+4*NCH -> no register changes.
- One-shot, WIDTH=16, NCH=2, ch0:
  - Setup: LO=F0, HI=FF, CTRL=0x0B (en, go, irq_en, presc 0).
  - Flag and irq rise exactly 16 cycles after the CTRL write edge, with a single rolloff[0] pulse.
  - running=0 afterwards and count reads 0xFFF0.
  - W1C STATUS=0x01 -> irq=0.
- Auto-reload with prescaler, ch1: reload 0xFFFC, CTRL=0x2F (presc 2) -> rolloff[1] pulses every 16 cycles for 3 periods, running stays 1, ch0 is unaffected.
- Freeze and atomic read:
  - Run ch0 from 0x00FE, set en=0 at count 0x0100, read LO then HI -> 0x00 and 0x01, with count unchanged for 20 cycles.
  - Set en=1 again -> counting resumes.
- Collisions:
  - W1C on the rolloff cycle -> flag stays 1.
  - go write on the rolloff cycle -> count=reload, running=1, flag=1.
  - rst=0 mid-count -> all state is 0 at the next edge.

Source files
------------

// File: rtl/timer_bamse_multi_if.sv
// 8-bit PicoBlaze port bus between the processor (master) and the timer (slave).
interface timer_bamse_multi_if;
  logic [7:0] address;
  logic [7:0] config_in;
  logic [7:0] config_out;
  logic       ren;
  logic       wen;

  modport master (output address, config_in, ren, wen, input config_out);
  modport slave  (input address, config_in, ren, wen, output config_out);
endinterface

// File: rtl/timer_bamse_multi.sv
// NCH independent prescaled up-counting timers on the PicoBlaze port bus,
// with one-shot/auto-reload, sticky W1C flags and a combined irq.
module timer_bamse_multi #(
  parameter logic [7:0] ADDR  = 8'h00,
  parameter int         NCH   = 2,
  parameter int         WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  timer_bamse_multi_if.slave        bus,
  output logic                      irq,
  output logic [NCH-1:0]            rolloff
);
  localparam logic [8:0]       SPAN = 9'(4 * NCH);
  localparam logic [WIDTH-1:0] CMAX = '1;
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  logic [7:0]     off;
  logic           hit;
  logic [7:0]     rd_ch [NCH];
  logic [NCH-1:0] irq_vec;
  logic [7:0]     config_out_q, config_out_d;

  // Offset arithmetic wraps in 8 bits so any ADDR base works.
  assign off = bus.address - ADDR;
  assign hit = ({1'b0, off} < SPAN);

  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    logic             sel, wr_ctrl, wr_stat, wr_lo, wr_hi, rd_lo, tick, at_max;
    logic [6:0]       pmax;
    logic [15:0]      wr16;
    logic [7:0]       rdata;
    logic             en_q, en_d, auto_q, auto_d, irq_en_q, irq_en_d;
    logic             running_q, running_d, flag_q, flag_d, roll_q, roll_d;
    logic [2:0]       presc_q, presc_d;
    logic [6:0]       pcnt_q, pcnt_d;
    logic [7:0]       lo_q, lo_d, shadow_q, shadow_d;
    logic [WIDTH-1:0] reload_q, reload_d, count_q, count_d;

    assign sel     = hit && (off[3:2] == 2'(gi));
    assign wr_ctrl = bus.wen && sel && (off[1:0] == 2'd0);
    assign wr_stat = bus.wen && sel && (off[1:0] == 2'd1);
    assign wr_lo   = bus.wen && sel && (off[1:0] == 2'd2);
    assign wr_hi   = bus.wen && sel && (off[1:0] == 2'd3);
    assign rd_lo   = bus.ren && sel && (off[1:0] == 2'd2);
    // 2^presc - 1; presc=7 wraps 128 to 0 and back to 127 in 7 bits.
    assign pmax    = (7'd1 << presc_q) - 7'd1;
    assign tick    = running_q && en_q && (pcnt_q == pmax);
    assign at_max  = (count_q == CMAX);
    assign wr16    = {bus.config_in, lo_q};

    always_comb begin
      en_d      = en_q;
      auto_d    = auto_q;
      irq_en_d  = irq_en_q;
      presc_d   = presc_q;
      reload_d  = reload_q;
      lo_d      = lo_q;
      count_d   = count_q;
      pcnt_d    = pcnt_q;
      running_d = running_q;
      flag_d    = flag_q;
      shadow_d  = shadow_q;
      roll_d    = 1'b0;
      if (running_q && en_q) pcnt_d = (pcnt_q == pmax) ? 7'd0 : pcnt_q + 7'd1;
      // Clear first so a simultaneous rolloff re-sets the flag.
      if (wr_stat && bus.config_in[0]) flag_d = 1'b0;
      if (tick) begin
        count_d = at_max ? reload_q : count_q + ONE;
        if (at_max) begin
          flag_d = 1'b1;
          roll_d = 1'b1;
          if (!auto_q) running_d = 1'b0;
        end
      end
      // CTRL write comes after the tick so go overrides a same-cycle rolloff.
      if (wr_ctrl) begin
        en_d     = bus.config_in[0];
        auto_d   = bus.config_in[2];
        irq_en_d = bus.config_in[3];
        presc_d  = bus.config_in[6:4];
        if (bus.config_in[1]) begin
          count_d   = reload_q;
          pcnt_d    = 7'd0;
          running_d = 1'b1;
        end
      end
      if (wr_lo) lo_d = bus.config_in;
      if (wr_hi) reload_d = wr16[WIDTH-1:0];
      if (rd_lo) shadow_d = 8'(count_q[WIDTH-1:8]);
    end

    always_ff @(posedge clk) begin
      if (!rst) begin
        en_q <= 1'b0; auto_q <= 1'b0; irq_en_q <= 1'b0; presc_q <= '0;
        reload_q <= '0; lo_q <= '0; count_q <= '0; pcnt_q <= '0;
        running_q <= 1'b0; flag_q <= 1'b0; shadow_q <= '0; roll_q <= 1'b0;
      end else begin
        en_q <= en_d; auto_q <= auto_d; irq_en_q <= irq_en_d; presc_q <= presc_d;
        reload_q <= reload_d; lo_q <= lo_d; count_q <= count_d; pcnt_q <= pcnt_d;
        running_q <= running_d; flag_q <= flag_d; shadow_q <= shadow_d; roll_q <= roll_d;
      end
    end

    always_comb begin
      case (off[1:0])
        2'd0:    rdata = {1'b0, presc_q, irq_en_q, auto_q, running_q, en_q};
        2'd1:    rdata = {6'd0, running_q, flag_q};
        2'd2:    rdata = count_q[7:0];
        default: rdata = shadow_q;
      endcase
    end

    assign rd_ch[gi]   = rdata;
    assign irq_vec[gi] = flag_q & irq_en_q;
    assign rolloff[gi] = roll_q;
  end

  always_comb begin
    config_out_d = 8'h00;
    if (bus.ren && hit) begin
      for (int c = 0; c < NCH; c++) begin
        if (off[3:2] == 2'(c)) config_out_d = rd_ch[c];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) config_out_q <= 8'h00;
    else      config_out_q <= config_out_d;
  end

  assign bus.config_out = config_out_q;
  assign irq            = |irq_vec;
endmodule

// File: tb/tb_timer_bamse_multi.sv
// Directed plus randomized checks of timer_bamse_multi against an arithmetic
// model of count value and rolloff times derived from reload and prescaler.
module tb_timer_bamse_multi;
  localparam int W = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       irq;
  logic [1:0] rolloff;
  int unsigned cyc = 0;
  int unsigned roll_q[2][$];
  int total = 0;
  int bad = 0;

  timer_bamse_multi_if bus ();

  timer_bamse_multi #(.ADDR(8'h00), .NCH(2), .WIDTH(W)) dut (
    .clk(clk), .rst(rst), .bus(bus), .irq(irq), .rolloff(rolloff)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    for (int c = 0; c < 2; c++) if (rolloff[c]) roll_q[c].push_back(cyc);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    bus.address = a; bus.config_in = d; bus.wen = 1'b1;
    @(negedge clk);
    bus.wen = 1'b0;
    $display("wr addr=%02h data=%02h", a, d);
  endtask

  task automatic rd(input logic [7:0] a, output logic [7:0] d);
    bus.address = a; bus.ren = 1'b1;
    @(negedge clk);
    bus.ren = 1'b0;
    d = bus.config_out;
    $display("rd addr=%02h data=%02h", a, d);
  endtask

  // Cycles from go to rolloff: (2^W - reload) * 2^presc.
  function automatic int unsigned period(input int unsigned r, input int p);
    return ((1 << W) - r) << p;
  endfunction

  // Count visible after e clock edges following the go edge.
  function automatic int unsigned model_count(input int unsigned r, input int p,
                                              input bit am, input int unsigned e);
    int unsigned ticks, span;
    ticks = e >> p;
    span  = (1 << W) - r;
    if (am) return r + (ticks % span);
    return (ticks >= span) ? r : r + ticks;
  endfunction

  initial begin
    logic [7:0]  d, d2, ctrl;
    int unsigned c0, e, r, per, wait_n, cnt, nexp;
    int          ch, p, base;
    bit          am;

    bus.address = 8'h00; bus.config_in = 8'h00; bus.ren = 1'b0; bus.wen = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_config_out", bus.config_out, 0);
    chk("reset_irq", irq, 0);
    chk("reset_rolloff", rolloff, 0);
    rst = 1'b1;
    for (int a = 0; a < 8; a++) begin rd(8'(a), d); chk("idle_read", d, 0); end
    wr(8'h08, 8'hFF); wr(8'h0A, 8'hFF); wr(8'h0B, 8'hFF); wr(8'hFF, 8'hFF);
    for (int a = 0; a < 8; a++) begin rd(8'(a), d); chk("oob_write_read", d, 0); end
    rd(8'h08, d); chk("oob_read_08", d, 0);
    rd(8'hFF, d); chk("oob_read_ff", d, 0);

    // One-shot ch0, reload 0xFFF0, presc 0.
    roll_q[0].delete();
    wr(8'h02, 8'hF0); wr(8'h03, 8'hFF); wr(8'h00, 8'h0B);
    c0 = cyc;
    per = period(32'hFFF0, 0);
    repeat (per - 1) @(negedge clk);
    chk("oneshot_irq_early", irq, 0);
    @(negedge clk);
    chk("oneshot_irq", irq, 1);
    chk("oneshot_roll", rolloff, 2'b01);
    @(negedge clk);
    chk("oneshot_roll_end", rolloff, 2'b00);
    chk("oneshot_roll_n", roll_q[0].size(), 1);
    if (roll_q[0].size() > 0) chk("oneshot_roll_t", roll_q[0][0], c0 + per);
    rd(8'h00, d); chk("oneshot_ctrl", d, 8'h09);
    rd(8'h01, d); chk("oneshot_status", d, 8'h01);
    rd(8'h02, d); rd(8'h03, d2); chk("oneshot_count", {d2, d}, 16'hFFF0);
    wr(8'h01, 8'h01);
    chk("w1c_irq", irq, 0);
    rd(8'h01, d); chk("w1c_status", d, 8'h00);

    // Auto-reload ch1, reload 0xFFFC, presc 2.
    roll_q[0].delete(); roll_q[1].delete();
    wr(8'h06, 8'hFC); wr(8'h07, 8'hFF); wr(8'h04, 8'h2F);
    c0 = cyc;
    per = period(32'hFFFC, 2);
    repeat (50) @(negedge clk);
    #1;
    chk("auto_roll_n", roll_q[1].size(), 3);
    for (int k = 0; k < 3 && k < roll_q[1].size(); k++)
      chk("auto_roll_t", roll_q[1][k], c0 + (k + 1) * per);
    chk("auto_ch0_quiet", roll_q[0].size(), 0);
    rd(8'h04, d); chk("auto_ctrl", d, 8'h2F);
    rd(8'h01, d); chk("auto_ch0_status", d, 8'h00);
    wr(8'h04, 8'h00); wr(8'h05, 8'h01);

    // Freeze at 0x0100 and atomic LO/HI read.
    wr(8'h02, 8'hFE); wr(8'h03, 8'h00); wr(8'h00, 8'h03);
    @(negedge clk);
    wr(8'h00, 8'h00);
    rd(8'h02, d); rd(8'h03, d2); chk("freeze_count", {d2, d}, 16'h0100);
    repeat (20) @(negedge clk);
    rd(8'h02, d); rd(8'h03, d2); chk("freeze_hold", {d2, d}, 16'h0100);
    rd(8'h00, d); chk("freeze_ctrl", d, 8'h02);
    wr(8'h00, 8'h01);
    repeat (5) @(negedge clk);
    rd(8'h02, d); rd(8'h03, d2); chk("resume_count", {d2, d}, 16'h0105);
    wr(8'h00, 8'h00);

    // W1C landing on the rolloff edge: set wins.
    roll_q[0].delete();
    wr(8'h02, 8'hFE); wr(8'h03, 8'hFF); wr(8'h01, 8'h01); wr(8'h00, 8'h0B);
    c0 = cyc;
    @(negedge clk);
    wr(8'h01, 8'h01);
    #1;
    chk("w1c_coll_irq", irq, 1);
    chk("w1c_coll_roll_t", roll_q[0].size() > 0 ? roll_q[0][0] : 0, c0 + 2);
    rd(8'h01, d); chk("w1c_coll_status", d, 8'h01);

    // go landing on the rolloff edge: restart wins, flag still set.
    wr(8'h01, 8'h01);
    chk("go_coll_pre_irq", irq, 0);
    wr(8'h00, 8'h0B);
    @(negedge clk);
    wr(8'h00, 8'h0B);
    rd(8'h02, d); chk("go_coll_count", d, 8'hFE);
    rd(8'h01, d); chk("go_coll_status", d, 8'h03);
    wr(8'h00, 8'h00); wr(8'h01, 8'h01);

    // Randomized runs against the arithmetic model.
    for (int it = 0; it < 6; it++) begin
      ch     = int'($urandom_range(0, 1));
      r      = (1 << W) - $urandom_range(1, 12);
      p      = int'($urandom_range(0, 3));
      am     = 1'($urandom_range(0, 1));
      per    = period(r, p);
      wait_n = am ? 2 * per + $urandom_range(0, per - 1) : per + $urandom_range(0, 5);
      base   = 4 * ch;
      ctrl   = {1'b0, 3'(p), 1'b1, am, 1'b1, 1'b1};
      wr(8'(base), 8'h00); wr(8'(base + 1), 8'h01);
      wr(8'(base + 2), r[7:0]); wr(8'(base + 3), r[15:8]);
      roll_q[ch].delete();
      wr(8'(base), ctrl);
      c0 = cyc;
      repeat (wait_n) @(negedge clk);
      e = cyc - c0;
      cnt = model_count(r, p, am, e);
      rd(8'(base + 2), d); rd(8'(base + 3), d2);
      chk("rand_count", {d2, d}, cnt[15:0]);
      rd(8'(base), d);
      chk("rand_ctrl", d, {ctrl[7:2], am, 1'b1});
      #1;
      nexp = am ? (cyc - c0) / per : 1;
      chk("rand_roll_n", roll_q[ch].size(), nexp);
      for (int k = 0; k < int'(nexp) && k < roll_q[ch].size(); k++)
        chk("rand_roll_t", roll_q[ch][k], c0 + (k + 1) * per);
      chk("rand_irq", irq, 1);
      wr(8'(base), 8'h00); wr(8'(base + 1), 8'h01);
    end

    // Reset mid-count with a read pending and irq active.
    wr(8'h06, 8'hFC); wr(8'h07, 8'hFF); wr(8'h04, 8'h2F);
    repeat (20) @(negedge clk);
    chk("prerst_irq", irq, 1);
    bus.address = 8'h06; bus.ren = 1'b1; rst = 1'b0;
    @(negedge clk);
    chk("midrst_config_out", bus.config_out, 0);
    chk("midrst_irq", irq, 0);
    chk("midrst_rolloff", rolloff, 0);
    bus.ren = 1'b0; rst = 1'b1;
    for (int a = 0; a < 8; a++) begin rd(8'(a), d); chk("postrst_read", d, 0); end
    repeat (20) @(negedge clk);
    chk("postrst_quiet", rolloff, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
